// File: rtl/pipe_exe_stage.sv
// Execute stage between the ID/EX and EX/MEM pipeline registers.
// Computes the single-cycle ALU result and the jal link address.
// Selects the destination register.
// Contains an iterative multiply/divide unit (MDU). While the MDU works, o_md_stall freezes
// PC, IF/ID and ID/EX, and EX/MEM receives a bubble.
//
// Ports:
//   i_clock, i_resetn       clock, synchronous active-low reset
//   i_ea, i_eb, i_eimm      operand A, operand B / store data, extended immediate
//   i_epc4, i_esa           PC+4 of the EX instruction, shift amount
//   i_ealuc, i_emd          ALU op, MDU op (00 none, 01 MUL, 10 DIVU, 11 REMU)
//   i_ealuimm .. i_ewmem    ID/EX control bits
//   i_ern0                  destination register before the jal override
//   o_ealu, o_ern           result and destination register to EX/MEM
//   o_xwreg/xm2reg/xwmem    controls to EX/MEM, squashed while stalling
//   o_md_stall              freeze request for the front of the pipe
module pipe_exe_stage #(
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned ITER_BITS = 1
) (
    input  logic              i_clock,
    input  logic              i_resetn,
    input  logic [DATA_W-1:0] i_ea,
    input  logic [DATA_W-1:0] i_eb,
    input  logic [DATA_W-1:0] i_eimm,
    input  logic [DATA_W-1:0] i_epc4,
    input  logic [4:0]        i_esa,
    input  logic [3:0]        i_ealuc,
    input  logic [1:0]        i_emd,
    input  logic              i_ealuimm,
    input  logic              i_eshift,
    input  logic              i_ejal,
    input  logic              i_ewreg,
    input  logic              i_em2reg,
    input  logic              i_ewmem,
    input  logic [4:0]        i_ern0,
    output logic [DATA_W-1:0] o_ealu,
    output logic [4:0]        o_ern,
    output logic              o_xwreg,
    output logic              o_xm2reg,
    output logic              o_xwmem,
    output logic              o_md_stall
);

    localparam int unsigned ITERS = DATA_W / ITER_BITS;
    localparam int unsigned CNT_W = $clog2(ITERS);

    typedef enum logic [1:0] {StIdle, StBusy, StDone} md_state_e;

    md_state_e         r_state;
    md_state_e         w_state_next;
    logic [CNT_W-1:0]  r_cnt;
    logic [1:0]        r_op;
    // MUL: r_opa multiplicand (shifts left), r_opb multiplier (shifts right), r_acc product.
    // DIV: r_opa dividend shifting out / quotient shifting in, r_opb divisor, r_acc remainder.
    logic [DATA_W-1:0] r_opa;
    logic [DATA_W-1:0] r_opb;
    logic [DATA_W-1:0] r_acc;

    logic              w_md_start;
    logic [DATA_W-1:0] w_opa_step;
    logic [DATA_W-1:0] w_opb_step;
    logic [DATA_W-1:0] w_acc_step;
    logic [DATA_W:0]   w_rem_wide;
    logic [DATA_W-1:0] w_md_result;
    logic [DATA_W-1:0] w_a;
    logic [DATA_W-1:0] w_b;
    logic [DATA_W-1:0] w_alu;

    assign w_md_start = (r_state == StIdle) && (i_emd != 2'b00);

    // ---------------- MDU FSM: state register ----------------
    always_ff @(posedge i_clock) begin
        if (!i_resetn) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ---------------- MDU FSM: next state ----------------
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle:  if (i_emd != 2'b00) w_state_next = StBusy;
            StBusy:  if (r_cnt == CNT_W'(ITERS - 1)) w_state_next = StDone;
            StDone:  w_state_next = StIdle;
            default: w_state_next = StIdle;
        endcase
    end

    // ---------------- MDU FSM: outputs ----------------
    always_comb begin
        o_md_stall  = w_md_start || (r_state == StBusy);
        w_md_result = (r_op == 2'b10) ? r_opa : r_acc;
    end

    // ITER_BITS shift-add or restoring-divide steps, unrolled.
    // A zero divisor always "fits", giving an all-ones quotient and remainder = dividend.
    always_comb begin
        w_opa_step = r_opa;
        w_opb_step = r_opb;
        w_acc_step = r_acc;
        w_rem_wide = '0;
        for (int i = 0; i < int'(ITER_BITS); i++) begin
            if (r_op == 2'b01) begin
                if (w_opb_step[0]) w_acc_step = w_acc_step + w_opa_step;
                w_opa_step = w_opa_step << 1;
                w_opb_step = w_opb_step >> 1;
            end else begin
                w_rem_wide = {w_acc_step, w_opa_step[DATA_W-1]};
                w_opa_step = w_opa_step << 1;
                if (w_rem_wide >= {1'b0, r_opb}) begin
                    w_rem_wide    = w_rem_wide - {1'b0, r_opb};
                    w_opa_step[0] = 1'b1;
                end
                w_acc_step = w_rem_wide[DATA_W-1:0];
            end
        end
    end

    // ---------------- MDU datapath registers ----------------
    always_ff @(posedge i_clock) begin
        if (!i_resetn) begin
            r_cnt <= '0;
            r_op  <= 2'b00;
            r_opa <= '0;
            r_opb <= '0;
            r_acc <= '0;
        end else if (w_md_start) begin
            r_cnt <= '0;
            r_op  <= i_emd;
            r_opa <= i_ea;
            r_opb <= i_eb;
            r_acc <= '0;
        end else if (r_state == StBusy) begin
            r_cnt <= r_cnt + CNT_W'(1);
            r_opa <= w_opa_step;
            r_opb <= w_opb_step;
            r_acc <= w_acc_step;
        end
    end

    // ---------------- Single-cycle ALU ----------------
    assign w_a = i_eshift ? {{(DATA_W - 5){1'b0}}, i_esa} : i_ea;
    assign w_b = i_ealuimm ? i_eimm : i_eb;

    always_comb begin
        w_alu = '0;
        unique case (i_ealuc[2:0])
            3'b000: w_alu = w_a + w_b;
            3'b100: w_alu = w_a - w_b;
            3'b001: w_alu = w_a & w_b;
            3'b101: w_alu = w_a | w_b;
            3'b010: w_alu = w_a ^ w_b;
            3'b110: w_alu = {w_b[15:0], 16'b0};
            3'b011: w_alu = w_b << w_a[4:0];
            3'b111: w_alu = i_ealuc[3] ? DATA_W'($signed(w_b) >>> w_a[4:0])
                                       : (w_b >> w_a[4:0]);
            default: w_alu = '0;
        endcase
    end

    // ---------------- Result and control outputs ----------------
    assign o_ealu   = i_ejal ? (i_epc4 + DATA_W'(4))
                             : ((i_emd != 2'b00) ? w_md_result : w_alu);
    assign o_ern    = i_ejal ? 5'd31 : i_ern0;
    assign o_xwreg  = i_ewreg  & ~o_md_stall;
    assign o_xm2reg = i_em2reg & ~o_md_stall;
    assign o_xwmem  = i_ewmem  & ~o_md_stall;

endmodule

// File: tb/tb_pipe_exe_stage.sv
module tb_pipe_exe_stage;

    localparam int ITERS = 32;

    logic        clk = 1'b0;
    logic        i_resetn;
    logic [31:0] i_ea, i_eb, i_eimm, i_epc4;
    logic [4:0]  i_esa, i_ern0;
    logic [3:0]  i_ealuc;
    logic [1:0]  i_emd;
    logic        i_ealuimm, i_eshift, i_ejal, i_ewreg, i_em2reg, i_ewmem;
    logic [31:0] o_ealu;
    logic [4:0]  o_ern;
    logic        o_xwreg, o_xm2reg, o_xwmem, o_md_stall;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    pipe_exe_stage #(.DATA_W(32), .ITER_BITS(1)) dut (
        .i_clock   (clk),
        .i_resetn  (i_resetn),
        .i_ea      (i_ea),
        .i_eb      (i_eb),
        .i_eimm    (i_eimm),
        .i_epc4    (i_epc4),
        .i_esa     (i_esa),
        .i_ealuc   (i_ealuc),
        .i_emd     (i_emd),
        .i_ealuimm (i_ealuimm),
        .i_eshift  (i_eshift),
        .i_ejal    (i_ejal),
        .i_ewreg   (i_ewreg),
        .i_em2reg  (i_em2reg),
        .i_ewmem   (i_ewmem),
        .i_ern0    (i_ern0),
        .o_ealu    (o_ealu),
        .o_ern     (o_ern),
        .o_xwreg   (o_xwreg),
        .o_xm2reg  (o_xm2reg),
        .o_xwmem   (o_xwmem),
        .o_md_stall(o_md_stall)
    );

    // Reference ALU from the instruction semantics.
    function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
        int unsigned s;
        s = a % 32;
        case (op[2:0])
            3'b000: return a + b;
            3'b100: return a - b;
            3'b001: return a & b;
            3'b101: return a | b;
            3'b010: return a ^ b;
            3'b110: return b << 16;
            3'b011: return b << s;
            default: begin
                if (op[3] && b[31]) return ~((~b) >> s);
                return b >> s;
            end
        endcase
    endfunction

    function automatic logic [31:0] ref_md(input logic [1:0] op, input logic [31:0] a,
                                           input logic [31:0] b);
        case (op)
            2'b01:   return a * b;
            2'b10:   return (b == 0) ? 32'hFFFF_FFFF : a / b;
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    task automatic zero_inputs();
        i_ea = '0; i_eb = '0; i_eimm = '0; i_epc4 = '0; i_esa = '0; i_ern0 = '0;
        i_ealuc = '0; i_emd = '0; i_ealuimm = 0; i_eshift = 0; i_ejal = 0;
        i_ewreg = 0; i_em2reg = 0; i_ewmem = 0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Runs one MDU op from a drive point; returns at the drive point after DONE.
    task automatic run_md(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input bit scramble, input string name);
        logic [31:0] exp;
        int          stalls;
        bit          done;
        bit          bad_ctl;
        exp = ref_md(op, a, b);
        i_ea = a; i_eb = b; i_emd = op; i_ejal = 0; i_ealuimm = 1'($urandom);
        i_eimm = $urandom; i_eshift = 1'($urandom); i_ealuc = 4'($urandom);
        i_ewreg = 1; i_em2reg = 1; i_ewmem = 1; i_ern0 = 5'($urandom);
        stalls = 0; done = 0; bad_ctl = 0;
        for (int cyc = 0; cyc < 3 * ITERS && !done; cyc++) begin
            @(negedge clk);
            if (o_md_stall) begin
                stalls++;
                if ({o_xwreg, o_xm2reg, o_xwmem} !== 3'b000) bad_ctl = 1;
            end else begin
                done = 1;
                n_checks++;
                if (o_ealu !== exp) begin
                    n_fail++;
                    $display("FAIL %s result: got %h expected %h", name, o_ealu, exp);
                end
                n_checks++;
                if ({o_xwreg, o_xm2reg, o_xwmem} !== 3'b111) begin
                    n_fail++;
                    $display("FAIL %s done ctl: got %b expected 111", name,
                             {o_xwreg, o_xm2reg, o_xwmem});
                end
            end
            next_cycle();
            if (!done && scramble) begin
                if (stalls < ITERS + 1) begin
                    i_ea = $urandom; i_eb = $urandom; i_emd = 2'($urandom_range(1, 3));
                end else begin
                    i_ea = a; i_eb = b; i_emd = op;
                end
            end
        end
        n_checks++;
        if (done !== 1'b1) begin
            n_fail++;
            $display("FAIL %s timeout: got no done expected done", name);
        end
        n_checks++;
        if (stalls !== ITERS + 1) begin
            n_fail++;
            $display("FAIL %s stall cycles: got %0d expected %0d", name, stalls, ITERS + 1);
        end
        n_checks++;
        if (bad_ctl !== 1'b0) begin
            n_fail++;
            $display("FAIL %s ctl during stall: got nonzero expected 000", name);
        end
        i_emd = 2'b00;
    endtask

    task automatic test_reset();
        zero_inputs();
        i_resetn = 0;
        next_cycle();
        next_cycle();
        @(negedge clk);
        n_checks++;
        if ({o_md_stall, o_ealu, o_ern, o_xwreg, o_xm2reg, o_xwmem} !== '0) begin
            n_fail++;
            $display("FAIL reset outputs: got stall=%b alu=%h ern=%0d expected all zero",
                     o_md_stall, o_ealu, o_ern);
        end
        next_cycle();
        i_ea = 5; i_eb = 7;
        @(negedge clk);
        n_checks++;
        if (o_ealu !== 32'd12) begin
            n_fail++;
            $display("FAIL reset comb follow: got %h expected 0000000c", o_ealu);
        end
        next_cycle();
        zero_inputs();
        i_resetn = 1;
    endtask

    task automatic check_alu_cycle(input string name, input logic [31:0] exp);
        @(negedge clk);
        n_checks++;
        if (o_ealu !== exp) begin
            n_fail++;
            $display("FAIL %s ealu: got %h expected %h", name, o_ealu, exp);
        end
        n_checks++;
        if (o_ern !== (i_ejal ? 5'd31 : i_ern0)) begin
            n_fail++;
            $display("FAIL %s ern: got %0d expected %0d", name, o_ern,
                     i_ejal ? 5'd31 : i_ern0);
        end
        n_checks++;
        if ({o_md_stall, o_xwreg, o_xm2reg, o_xwmem} !== {1'b0, i_ewreg, i_em2reg, i_ewmem})
        begin
            n_fail++;
            $display("FAIL %s stall/ctl: got %b expected %b", name,
                     {o_md_stall, o_xwreg, o_xm2reg, o_xwmem},
                     {1'b0, i_ewreg, i_em2reg, i_ewmem});
        end
        next_cycle();
    endtask

    task automatic test_directed_alu();
        zero_inputs();
        i_ea = 5; i_eb = 7; i_ealuc = 4'b0000; i_ewreg = 1;
        check_alu_cycle("add", 32'd12);
        zero_inputs();
        i_eshift = 1; i_esa = 4; i_eb = 32'h8000_0000; i_ealuc = 4'b1111; i_ewreg = 1;
        check_alu_cycle("sra", 32'hF800_0000);
        zero_inputs();
        i_ejal = 1; i_epc4 = 32'h100; i_ern0 = 3; i_ewreg = 1;
        check_alu_cycle("jal", 32'h104);
        zero_inputs();
        i_ealuimm = 1; i_eimm = 32'h0000_ABCD; i_ealuc = 4'b0110; i_ern0 = 9;
        check_alu_cycle("lui", 32'hABCD_0000);
    endtask

    task automatic test_random_alu();
        logic [31:0] a, b;
        for (int n = 0; n < 40; n++) begin
            i_ea = $urandom; i_eb = $urandom; i_eimm = $urandom; i_epc4 = $urandom;
            i_esa = 5'($urandom); i_ern0 = 5'($urandom); i_emd = 2'b00;
            do i_ealuc = 4'($urandom); while (i_ealuc == 4'b1011);
            i_ealuimm = 1'($urandom); i_eshift = 1'($urandom);
            i_ejal = ($urandom_range(0, 7) == 0);
            i_ewreg = 1'($urandom); i_em2reg = 1'($urandom); i_ewmem = 1'($urandom);
            a = i_eshift ? 32'(i_esa) : i_ea;
            b = i_ealuimm ? i_eimm : i_eb;
            check_alu_cycle("rand_alu", i_ejal ? i_epc4 + 32'd4 : ref_alu(i_ealuc, a, b));
        end
        zero_inputs();
    endtask

    task automatic test_mul();
        run_md(2'b01, 32'hFFFF_FFFF, 32'd3, 0, "mul");
    endtask

    task automatic test_back_to_back();
        run_md(2'b10, 32'd100, 32'd7, 0, "divu");
        run_md(2'b11, 32'd100, 32'd7, 0, "remu");
        run_md(2'b10, 32'd9, 32'd0, 0, "divu0");
        run_md(2'b11, 32'd9, 32'd0, 0, "remu0");
        zero_inputs();
    endtask

    task automatic test_reset_midop();
        run_md(2'b01, 32'd0, 32'd0, 0, "mul_pre");
        i_ea = 32'h1234_5678; i_eb = 32'h9ABC_DEF0; i_emd = 2'b01; i_ewreg = 1;
        for (int n = 0; n < 11; n++) next_cycle();
        zero_inputs();
        i_resetn = 0;
        next_cycle();
        i_resetn = 1;
        @(negedge clk);
        n_checks++;
        if (o_md_stall !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_midop stall: got %b expected 0", o_md_stall);
        end
        next_cycle();
        run_md(2'b01, 32'd6, 32'd7, 0, "mul_after_reset");
        zero_inputs();
    endtask

    task automatic test_random_mdu();
        logic [31:0] a, b;
        for (int n = 0; n < 8; n++) begin
            a = $urandom;
            b = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
            if (n % 3 == 0) b = b >> $urandom_range(0, 31);
            run_md(2'($urandom_range(1, 3)), a, b, (n % 2) == 1, "rand_md");
        end
        zero_inputs();
    endtask

    initial begin
        test_reset();
        test_directed_alu();
        test_random_alu();
        test_mul();
        test_back_to_back();
        test_reset_midop();
        test_random_mdu();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
